// File: rtl/instruction_loader.sv
// instruction_loader
//   Write-side companion of the fetch path. Accepts a stream of 32-bit
//   instruction words over a valid/ready handshake and writes them into the
//   instruction memory write port at consecutive word addresses. The CPU is
//   held in reset (cpu_hold_o) until an image has loaded cleanly.
//
//   Optional feature macro: LOADER_CHECKSUM_EN adds checksum_o, the mod-2^32
//   sum of all words accepted since the last start.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        begin a load (ignored while loading)
//   base_addr_i    byte start address, sampled on accepted start
//   in_valid_i     in_data_i / in_last_i valid
//   in_data_i      instruction word
//   in_last_i      final word of the image
//   in_ready_o     loader can accept a word
//   wr_en_o        imem write strobe, one cycle per word
//   wr_addr_o      imem byte address (word-aligned)
//   wr_data_o      imem write data
//   word_count_o   words written since last start
//   busy_o         loading
//   done_o         image loaded cleanly
//   error_o        misaligned start or image overran memory
//   cpu_hold_o     hold PC/fetch in reset; low only when done
//   checksum_o     (LOADER_CHECKSUM_EN only) sum of accepted words
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | accepting words, writing one per transfer
// DONE  | image terminated by in_last, CPU released
// ERROR | misaligned base address or write past the last word

module instruction_loader #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [31:0]       base_addr_i,
    input  logic              in_valid_i,
    input  logic [31:0]       in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [31:0]       wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [IDX_W:0]    word_count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              cpu_hold_o
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W:0]     word_count_q;
    logic               in_ready_q, wr_en_q, busy_q, done_q, error_q, cpu_hold_q;
    logic [31:0]        wr_addr_q, wr_data_q;

    logic start_acc, aligned, xfer, at_last;

    // Upper address bits beyond the memory span are deliberately ignored.
    logic unused_base_bits;
    assign unused_base_bits = ^base_addr_i[31:IDX_W+2];

    assign start_acc = start_i && (state_q != S_LOAD);
    assign aligned   = (base_addr_i[1:0] == 2'b00);
    // in_ready_q is only ever set while the FSM sits in LOAD.
    assign xfer      = in_valid_i && in_ready_q;
    assign at_last   = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    if (in_last_i)    state_d = S_DONE;
                    else if (at_last) state_d = S_ERROR;
                end
            end
            default: begin
                if (start_i) state_d = aligned ? S_LOAD : S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Status outputs are decoded from the next state so they line up
            // with state_q on the following cycle.
            in_ready_q <= (state_d == S_LOAD);
            busy_q     <= (state_d == S_LOAD);
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERROR);
            cpu_hold_q <= (state_d != S_DONE);
            wr_en_q    <= xfer;

            if (start_acc) begin
                word_count_q <= '0;
                idx_q        <= base_addr_i[IDX_W+1:2];
            end else if (xfer) begin
                wr_addr_q    <= {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                wr_data_q    <= in_data_i;
                word_count_q <= word_count_q + (IDX_W+1)'(1);
                // Saturate at the top word; an overrun goes to ERROR anyway.
                if (!at_last) idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        checksum_q <= '0;
        else if (start_acc) checksum_q <= '0;
        else if (xfer)      checksum_q <= checksum_q + in_data_i;
    end

    assign checksum_o = checksum_q;
`endif

    assign in_ready_o   = in_ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign word_count_o = word_count_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign cpu_hold_o   = cpu_hold_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  word_count;
    logic        busy, done, error, cpu_hold;
    logic [31:0] checksum;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    instruction_loader #(.DEPTH(64), .IDX_W(6)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .word_count_o (word_count),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .cpu_hold_o   (cpu_hold)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum_o   (checksum)
`endif
    );

`ifndef LOADER_CHECKSUM_EN
    assign checksum = 32'h0;
`endif

    typedef struct {
        logic        start;
        logic [31:0] base;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        e_rdy;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [6:0]  e_wc;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic        e_hold;
        logic [31:0] e_chk;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic st, input logic [31:0] b, input logic v, input logic [31:0] d, input logic l,
        input logic rdy, input logic we, input logic [31:0] a, input logic [31:0] wd,
        input logic [6:0] wc, input logic bs, input logic dn, input logic er, input logic hd,
        input logic [31:0] ck);
        vec_t r;
        r.start = st; r.base = b; r.valid = v; r.data = d; r.last = l;
        r.e_rdy = rdy; r.e_we = we; r.e_addr = a; r.e_wdata = wd; r.e_wc = wc;
        r.e_busy = bs; r.e_done = dn; r.e_err = er; r.e_hold = hd; r.e_chk = ck;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic we,
                              input logic [31:0] a, input logic [31:0] wd, input logic [6:0] wc,
                              input logic bs, input logic dn, input logic er, input logic hd,
                              input logic [31:0] ck);
        chk({tag, ".in_ready"},   {31'b0, in_ready}, {31'b0, rdy});
        chk({tag, ".wr_en"},      {31'b0, wr_en},    {31'b0, we});
        if (we) begin
            chk({tag, ".wr_addr"}, wr_addr, a);
            chk({tag, ".wr_data"}, wr_data, wd);
        end
        chk({tag, ".word_count"}, {25'b0, word_count}, {25'b0, wc});
        chk({tag, ".busy"},       {31'b0, busy},     {31'b0, bs});
        chk({tag, ".done"},       {31'b0, done},     {31'b0, dn});
        chk({tag, ".error"},      {31'b0, error},    {31'b0, er});
        chk({tag, ".cpu_hold"},   {31'b0, cpu_hold}, {31'b0, hd});
`ifdef LOADER_CHECKSUM_EN
        chk({tag, ".checksum"},   checksum, ck);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check_outs(tag, 0, 0, 32'h0, 32'h0, 7'd0, 0, 0, 0, 1, 32'h0);
        chk({tag, ".wr_addr_rst"}, wr_addr, 32'h0);
        chk({tag, ".wr_data_rst"}, wr_data, 32'h0);
    endtask

    localparam logic [31:0] A = 32'h0000_0013, B = 32'h0010_0093, C = 32'h0020_0113;
    localparam logic [31:0] D = 32'h0BAD_F00D, E = 32'h1111_1111, F = 32'h2222_2222;
    localparam logic [31:0] G = 32'hFFFF_FFFF, H = 32'h0000_0002, I = 32'hBADB_AD00;
    localparam logic [31:0] J = 32'hA5A5_A5A5, K = 32'h0000_0100, L = 32'h0000_0023;
    localparam logic [31:0] M = 32'h0000_CAFE, N = 32'h1234_5678;

    initial begin
        //              st base          v  data  l   rdy we addr         wdata wc   bsy dn er hd  chk
        vecs[0]  = mk(1, 32'h0,        0, 32'h0, 0,  1, 0, 32'h0,       32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        vecs[1]  = mk(0, 32'h0,        1, A,     0,  1, 1, 32'h0,       A,     7'd1, 1, 0, 0, 1, 32'h0000_0013);
        vecs[2]  = mk(0, 32'h0,        1, B,     0,  1, 1, 32'h4,       B,     7'd2, 1, 0, 0, 1, 32'h0010_00A6);
        vecs[3]  = mk(0, 32'h0,        1, C,     1,  0, 1, 32'h8,       C,     7'd3, 0, 1, 0, 0, 32'h0030_01B9);
        vecs[4]  = mk(0, 32'h0,        1, D,     0,  0, 0, 32'h0,       32'h0, 7'd3, 0, 1, 0, 0, 32'h0030_01B9);
        vecs[5]  = mk(1, 32'h3C,       0, 32'h0, 0,  1, 0, 32'h0,       32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        vecs[6]  = mk(0, 32'h0,        1, E,     0,  1, 1, 32'h3C,      E,     7'd1, 1, 0, 0, 1, 32'h1111_1111);
        vecs[7]  = mk(0, 32'h0,        0, F,     0,  1, 0, 32'h0,       32'h0, 7'd1, 1, 0, 0, 1, 32'h1111_1111);
        vecs[8]  = mk(0, 32'h0,        1, F,     1,  0, 1, 32'h40,      F,     7'd2, 0, 1, 0, 0, 32'h3333_3333);
        vecs[9]  = mk(1, 32'hF8,       0, 32'h0, 0,  1, 0, 32'h0,       32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        vecs[10] = mk(0, 32'h0,        1, G,     0,  1, 1, 32'hF8,      G,     7'd1, 1, 0, 0, 1, 32'hFFFF_FFFF);
        vecs[11] = mk(0, 32'h0,        1, H,     0,  0, 1, 32'hFC,      H,     7'd2, 0, 0, 1, 1, 32'h0000_0001);
        vecs[12] = mk(0, 32'h0,        1, I,     0,  0, 0, 32'h0,       32'h0, 7'd2, 0, 0, 1, 1, 32'h0000_0001);
        vecs[13] = mk(1, 32'h0,        0, 32'h0, 0,  1, 0, 32'h0,       32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        vecs[14] = mk(0, 32'h0,        1, J,     1,  0, 1, 32'h0,       J,     7'd1, 0, 1, 0, 0, 32'hA5A5_A5A5);
        vecs[15] = mk(1, 32'h2,        0, 32'h0, 0,  0, 0, 32'h0,       32'h0, 7'd0, 0, 0, 1, 1, 32'h0);
        vecs[16] = mk(1, 32'h0,        0, 32'h0, 0,  1, 0, 32'h0,       32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        vecs[17] = mk(1, 32'h10,       1, K,     0,  1, 1, 32'h0,       K,     7'd1, 1, 0, 0, 1, 32'h0000_0100);
        vecs[18] = mk(0, 32'h0,        1, L,     1,  0, 1, 32'h4,       L,     7'd2, 0, 1, 0, 0, 32'h0000_0123);
        vecs[19] = mk(1, 32'hFFFF_FF04, 0, 32'h0, 0, 1, 0, 32'h0,       32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        vecs[20] = mk(0, 32'h0,        1, M,     1,  0, 1, 32'h4,       M,     7'd1, 0, 1, 0, 0, 32'h0000_CAFE);

        rst_n = 1'b0; start = 1'b0; base_addr = 32'h0;
        in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;

        #12;
        check_reset_vals("reset");
        @(posedge clk); #1;
        check_reset_vals("reset_clocked");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            start = vecs[i].start; base_addr = vecs[i].base;
            in_valid = vecs[i].valid; in_data = vecs[i].data; in_last = vecs[i].last;
            @(posedge clk); #1;
            check_outs($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_addr,
                       vecs[i].e_wdata, vecs[i].e_wc, vecs[i].e_busy, vecs[i].e_done,
                       vecs[i].e_err, vecs[i].e_hold, vecs[i].e_chk);
        end

        // Asynchronous reset in the middle of a 4-word load.
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = A;
        @(negedge clk);
        in_data = B;
        @(posedge clk); #1;
        check_outs("mid_load", 1, 1, 32'h4, B, 7'd2, 1, 0, 0, 1, A + B);
        @(negedge clk);
        in_data = C;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk); #1;
        check_reset_vals("async_rst_held");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs("post_rst_idle", 0, 0, 32'h0, 32'h0, 7'd0, 0, 0, 0, 1, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1; base_addr = 32'h0;
        @(posedge clk); #1;
        check_outs("reload_start", 1, 0, 32'h0, 32'h0, 7'd0, 1, 0, 0, 1, 32'h0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = N; in_last = 1'b1;
        @(posedge clk); #1;
        check_outs("reload_word0", 0, 1, 32'h0, N, 7'd1, 0, 1, 0, 0, N);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
